// File: rtl/decode_sequencer.sv
// Phase controller for the decompressor: UART receive -> IDCT (M2) -> upsample/CSC (M1) -> VGA,
// owning the single SRAM port. Optional per-phase watchdog enabled with `define SEQ_WATCHDOG_EN.
`timescale 1ns/1ps
module decode_sequencer #(
  parameter int unsigned UART_TIMEOUT = 49999999,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned TIMER_W      = 26,
  parameter int unsigned WDOG_CYCLES  = 8000000
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        UART_RX_I,
  output logic        uart_rx_initialize,
  output logic        uart_rx_enable,
  input  logic [17:0] uart_sram_address,
  input  logic [15:0] uart_sram_write_data,
  input  logic        uart_sram_we_n,
  output logic        m2_start,
  input  logic        m2_done,
  input  logic [17:0] m2_sram_address,
  input  logic [15:0] m2_sram_write_data,
  input  logic        m2_sram_we_n,
  output logic        m1_start,
  input  logic        m1_done,
  input  logic [17:0] m1_sram_address,
  input  logic [15:0] m1_sram_write_data,
  input  logic        m1_sram_we_n,
  output logic        vga_enable,
  input  logic [17:0] vga_sram_address,
  output logic [17:0] sram_address,
  output logic [15:0] sram_write_data,
  output logic        sram_we_n,
  output logic [2:0]  seq_state,
  output logic        seq_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_GUARD   = 3'd2,
    S_M2      = 3'd3,
    S_M1      = 3'd4
`ifdef SEQ_WATCHDOG_EN
    , S_ERR   = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_UART = 3'd1,
    OWN_M2   = 3'd2,
    OWN_M1   = 3'd3,
    OWN_VGA  = 3'd4
  } owner_t;

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]      GUARD_LAST = GW'(GUARD_CYCLES - 1);
  // The edge that would bring the timer to UART_TIMEOUT ends the receive phase.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(UART_TIMEOUT - 1);

  state_t              state, state_nxt;
  state_t              next_phase, next_phase_nxt;
  owner_t              owner, owner_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [GW-1:0]       guard_cnt, guard_nxt;
  logic                init_nxt, en_nxt, vga_nxt, m2s_nxt, m1s_nxt;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt, wdog_nxt;
  logic          seq_error_q, err_nxt;
  assign seq_error = seq_error_q;
`else
  assign seq_error = 1'b0;
`endif

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      next_phase         <= S_IDLE;
      owner              <= OWN_VGA;
      timer              <= '0;
      guard_cnt          <= '0;
      uart_rx_initialize <= 1'b0;
      uart_rx_enable     <= 1'b0;
      vga_enable         <= 1'b1;
      m2_start           <= 1'b0;
      m1_start           <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdog_cnt           <= '0;
      seq_error_q        <= 1'b0;
`endif
    end else begin
      state              <= state_nxt;
      next_phase         <= next_phase_nxt;
      owner              <= owner_nxt;
      timer              <= timer_nxt;
      guard_cnt          <= guard_nxt;
      uart_rx_initialize <= init_nxt;
      uart_rx_enable     <= en_nxt;
      vga_enable         <= vga_nxt;
      m2_start           <= m2s_nxt;
      m1_start           <= m1s_nxt;
`ifdef SEQ_WATCHDOG_EN
      wdog_cnt           <= wdog_nxt;
      seq_error_q        <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    next_phase_nxt = next_phase;
    owner_nxt      = owner;
    timer_nxt      = timer;
    guard_nxt      = guard_cnt;
    init_nxt       = 1'b0;
    en_nxt         = 1'b0;
    vga_nxt        = vga_enable;
    m2s_nxt        = m2_start;
    m1s_nxt        = m1_start;
`ifdef SEQ_WATCHDOG_EN
    wdog_nxt       = wdog_cnt;
    err_nxt        = seq_error_q;
`endif
    case (state)
      S_IDLE: begin
        if (!UART_RX_I) begin
          init_nxt  = 1'b1;
          vga_nxt   = 1'b0;
          timer_nxt = '0;
          owner_nxt = OWN_UART;
          state_nxt = S_UART_RX;
        end
      end
      S_UART_RX: begin
        en_nxt = uart_rx_initialize;
        if (!uart_sram_we_n) begin
          timer_nxt = '0;
        end else if (timer == TIMER_LAST) begin
          timer_nxt      = '0;
          owner_nxt      = OWN_NONE;
          next_phase_nxt = S_M2;
          guard_nxt      = '0;
          state_nxt      = S_GUARD;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = next_phase;
          case (next_phase)
            S_M2: begin
              owner_nxt = OWN_M2;
              m2s_nxt   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
              wdog_nxt  = '0;
`endif
            end
            S_M1: begin
              owner_nxt = OWN_M1;
              m1s_nxt   = 1'b1;
`ifdef SEQ_WATCHDOG_EN
              wdog_nxt  = '0;
`endif
            end
            default: begin
              state_nxt = S_IDLE;
              owner_nxt = OWN_VGA;
              vga_nxt   = 1'b1;
            end
          endcase
        end else begin
          guard_nxt = guard_cnt + 1'b1;
        end
      end
      S_M2: begin
        if (m2_done) begin
          m2s_nxt        = 1'b0;
          owner_nxt      = OWN_NONE;
          next_phase_nxt = S_M1;
          guard_nxt      = '0;
          state_nxt      = S_GUARD;
`ifdef SEQ_WATCHDOG_EN
        end else if (wdog_cnt == WDOG_LAST) begin
          m2s_nxt   = 1'b0;
          owner_nxt = OWN_NONE;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          wdog_nxt = wdog_cnt + 1'b1;
`endif
        end
      end
      S_M1: begin
        if (m1_done) begin
          m1s_nxt        = 1'b0;
          owner_nxt      = OWN_NONE;
          next_phase_nxt = S_IDLE;
          guard_nxt      = '0;
          state_nxt      = S_GUARD;
`ifdef SEQ_WATCHDOG_EN
        end else if (wdog_cnt == WDOG_LAST) begin
          m1s_nxt   = 1'b0;
          owner_nxt = OWN_NONE;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          wdog_nxt = wdog_cnt + 1'b1;
`endif
        end
      end
`ifdef SEQ_WATCHDOG_EN
      // Terminal until reset: bus idle, display off.
      S_ERR: begin
        owner_nxt = OWN_NONE;
        vga_nxt   = 1'b0;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        owner_nxt = OWN_VGA;
        vga_nxt   = 1'b1;
        m2s_nxt   = 1'b0;
        m1s_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    sram_address    = '0;
    sram_write_data = '0;
    sram_we_n       = 1'b1;
    case (owner)
      OWN_UART: begin
        sram_address    = uart_sram_address;
        sram_write_data = uart_sram_write_data;
        sram_we_n       = uart_sram_we_n;
      end
      OWN_M2: begin
        sram_address    = m2_sram_address;
        sram_write_data = m2_sram_write_data;
        sram_we_n       = m2_sram_we_n;
      end
      OWN_M1: begin
        sram_address    = m1_sram_address;
        sram_write_data = m1_sram_write_data;
        sram_we_n       = m1_sram_we_n;
      end
      OWN_VGA: sram_address = vga_sram_address;
      default: ;
    endcase
  end

  assign seq_state = state;

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: phase walk, bus ownership, guard gaps, reset and watchdog.
`timescale 1ns/1ps
module tb_decode_sequencer;
  localparam int UT = 100;
  localparam int GC = 2;
  localparam int WD = 1000;

  localparam logic [17:0] UA  = 18'h00123;
  localparam logic [15:0] UD  = 16'hA5A5;
  localparam logic [17:0] M2A = 18'h2ABCD;
  localparam logic [15:0] M2D = 16'h1234;
  localparam logic [17:0] M1A = 18'h3F00F;
  localparam logic [15:0] M1D = 16'hBEEF;
  localparam logic [17:0] VA  = 18'h15555;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn = 1'b0;
  logic        UART_RX_I = 1'b1;
  logic        uart_rx_initialize, uart_rx_enable;
  logic [17:0] uart_sram_address = UA;
  logic [15:0] uart_sram_write_data = UD;
  logic        uart_sram_we_n = 1'b1;
  logic        m2_start;
  logic        m2_done = 1'b0;
  logic [17:0] m2_sram_address = M2A;
  logic [15:0] m2_sram_write_data = M2D;
  logic        m2_sram_we_n = 1'b1;
  logic        m1_start;
  logic        m1_done = 1'b0;
  logic [17:0] m1_sram_address = M1A;
  logic [15:0] m1_sram_write_data = M1D;
  logic        m1_sram_we_n = 1'b1;
  logic        vga_enable;
  logic [17:0] vga_sram_address = VA;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        sram_we_n;
  logic [2:0]  seq_state;
  logic        seq_error;

  int nchk = 0;
  int nerr = 0;
  logic [34:0] exp_q[$];

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  decode_sequencer #(
    .UART_TIMEOUT(UT), .GUARD_CYCLES(GC), .TIMER_W(26), .WDOG_CYCLES(WD)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .UART_RX_I(UART_RX_I),
    .uart_rx_initialize(uart_rx_initialize), .uart_rx_enable(uart_rx_enable),
    .uart_sram_address(uart_sram_address), .uart_sram_write_data(uart_sram_write_data),
    .uart_sram_we_n(uart_sram_we_n),
    .m2_start(m2_start), .m2_done(m2_done), .m2_sram_address(m2_sram_address),
    .m2_sram_write_data(m2_sram_write_data), .m2_sram_we_n(m2_sram_we_n),
    .m1_start(m1_start), .m1_done(m1_done), .m1_sram_address(m1_sram_address),
    .m1_sram_write_data(m1_sram_write_data), .m1_sram_we_n(m1_sram_we_n),
    .vga_enable(vga_enable), .vga_sram_address(vga_sram_address),
    .sram_address(sram_address), .sram_write_data(sram_write_data), .sram_we_n(sram_we_n),
    .seq_state(seq_state), .seq_error(seq_error)
  );

  // Bounded wait for a state, observed on falling edges.
  task automatic wait_state(input logic [2:0] s, input int lim);
    int n;
    n = 0;
    while (seq_state !== s && n < lim) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    nchk++;
    if (seq_state !== s) begin
      nerr++;
      $display("FAIL wait_state: state %0d, required %0d", seq_state, s);
    end
  endtask

  task automatic test_reset();
    logic [34:0] got, ex;
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    nchk++; if (seq_state !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d required 0", seq_state); end
    nchk++; if (vga_enable !== 1'b1) begin nerr++; $display("FAIL rst_vga: got %b required 1", vga_enable); end
    nchk++; if ({m2_start, m1_start} !== 2'b00) begin nerr++; $display("FAIL rst_starts: got %b required 00", {m2_start, m1_start}); end
    nchk++; if ({seq_error, uart_rx_initialize, uart_rx_enable} !== 3'b000) begin nerr++; $display("FAIL rst_pulses: got %b required 000", {seq_error, uart_rx_initialize, uart_rx_enable}); end
    exp_q.push_back({VA, 16'h0, 1'b1});
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL rst_bus: got %h required %h", got, ex); end
    resetn = 1'b1;
  endtask

  task automatic test_uart_rx();
    logic [34:0] got, ex;
    int k;
    repeat (10) @(negedge CLOCK_50_I);
    nchk++; if (seq_state !== 3'd0) begin nerr++; $display("FAIL idle_hold: got %0d required 0", seq_state); end
    UART_RX_I = 1'b0;
    @(negedge CLOCK_50_I);
    UART_RX_I = 1'b1;
    nchk++; if ({seq_state, uart_rx_initialize, uart_rx_enable, vga_enable} !== {3'd1, 3'b100})
      begin nerr++; $display("FAIL uart_entry: got st=%0d init=%b en=%b vga=%b required 1/1/0/0", seq_state, uart_rx_initialize, uart_rx_enable, vga_enable); end
    @(negedge CLOCK_50_I);
    nchk++; if ({uart_rx_initialize, uart_rx_enable} !== 2'b01) begin nerr++; $display("FAIL uart_enable: got %b required 01", {uart_rx_initialize, uart_rx_enable}); end
    uart_sram_we_n = 1'b0;
    exp_q.push_back({UA, UD, 1'b0});
    #1;
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL uart_bus: got %h required %h", got, ex); end
    @(negedge CLOCK_50_I);
    uart_sram_we_n = 1'b1;
    nchk++; if (uart_rx_enable !== 1'b0) begin nerr++; $display("FAIL uart_enable_drop: got %b required 0", uart_rx_enable); end
    // Count rising edges after the edge that sampled the last write.
    k = 0;
    while (seq_state !== 3'd2 && k < 3 * UT) begin
      @(negedge CLOCK_50_I);
      k++;
    end
    nchk++; if (k !== UT) begin nerr++; $display("FAIL uart_timeout: got %0d cycles required %0d", k, UT); end
  endtask

  task automatic test_guard_to_m2();
    logic [34:0] got, ex;
    uart_sram_we_n = 1'b0;
    exp_q.push_back({18'h0, 16'h0, 1'b1});
    #1;
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL guard1_bus: got %h required %h", got, ex); end
    @(negedge CLOCK_50_I);
    exp_q.push_back({18'h0, 16'h0, 1'b1});
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (seq_state !== 3'd2 || got !== ex) begin nerr++; $display("FAIL guard2: got st=%0d bus=%h required 2/%h", seq_state, got, ex); end
    uart_sram_we_n = 1'b1;
    @(negedge CLOCK_50_I);
    nchk++; if ({seq_state, m2_start, m1_start} !== {3'd3, 2'b10}) begin nerr++; $display("FAIL m2_entry: got st=%0d m2s=%b m1s=%b required 3/1/0", seq_state, m2_start, m1_start); end
    m2_sram_we_n = 1'b0;
    exp_q.push_back({M2A, M2D, 1'b0});
    #1;
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL m2_bus: got %h required %h", got, ex); end
  endtask

  task automatic test_m2_m1();
    logic [34:0] got, ex;
    m1_done = 1'b1;
    @(negedge CLOCK_50_I);
    m1_done = 1'b0;
    nchk++; if ({seq_state, m2_start} !== {3'd3, 1'b1}) begin nerr++; $display("FAIL m2_foreign_done: got st=%0d m2s=%b required 3/1", seq_state, m2_start); end
    m2_done = 1'b1;
    @(negedge CLOCK_50_I);
    m2_done = 1'b0;
    nchk++; if ({seq_state, m2_start, sram_we_n} !== {3'd2, 2'b01}) begin nerr++; $display("FAIL m2_done: got st=%0d m2s=%b we_n=%b required 2/0/1", seq_state, m2_start, sram_we_n); end
    @(negedge CLOCK_50_I);
    nchk++; if ({seq_state, sram_we_n} !== {3'd2, 1'b1}) begin nerr++; $display("FAIL m1_guard: got st=%0d we_n=%b required 2/1", seq_state, sram_we_n); end
    @(negedge CLOCK_50_I);
    m2_sram_we_n = 1'b1;
    nchk++; if ({seq_state, m1_start, m2_start} !== {3'd4, 2'b10}) begin nerr++; $display("FAIL m1_entry: got st=%0d m1s=%b m2s=%b required 4/1/0", seq_state, m1_start, m2_start); end
    m1_sram_we_n = 1'b0;
    exp_q.push_back({M1A, M1D, 1'b0});
    #1;
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL m1_bus: got %h required %h", got, ex); end
    m1_done = 1'b1;
    @(negedge CLOCK_50_I);
    nchk++; if ({seq_state, m1_start} !== {3'd2, 1'b0}) begin nerr++; $display("FAIL m1_done: got st=%0d m1s=%b required 2/0", seq_state, m1_start); end
    repeat (2) @(negedge CLOCK_50_I);
    exp_q.push_back({VA, 16'h0, 1'b1});
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if ({seq_state, vga_enable} !== {3'd0, 1'b1} || got !== ex) begin nerr++; $display("FAIL back_to_idle: got st=%0d vga=%b bus=%h required 0/1/%h", seq_state, vga_enable, got, ex); end
    @(negedge CLOCK_50_I);
    m1_done = 1'b0;
    m1_sram_we_n = 1'b1;
    nchk++; if ({seq_state, m1_start, m2_start} !== {3'd0, 2'b00}) begin nerr++; $display("FAIL idle_level_done: got st=%0d starts=%b required 0/00", seq_state, {m1_start, m2_start}); end
  endtask

  task automatic test_reset_mid_m1();
    logic [34:0] got, ex;
    UART_RX_I = 1'b0;
    @(negedge CLOCK_50_I);
    UART_RX_I = 1'b1;
    wait_state(3'd2, UT + 20);
    wait_state(3'd3, 10);
    m2_done = 1'b1;
    @(negedge CLOCK_50_I);
    m2_done = 1'b0;
    nchk++; if (seq_state !== 3'd2) begin nerr++; $display("FAIL first_cycle_done: got %0d required 2", seq_state); end
    wait_state(3'd4, 10);
    m1_sram_we_n = 1'b0;
    exp_q.push_back({M1A, M1D, 1'b0});
    #1;
    got = {sram_address, sram_write_data, sram_we_n}; ex = exp_q.pop_front();
    nchk++; if (got !== ex) begin nerr++; $display("FAIL m1_bus_pre_reset: got %h required %h", got, ex); end
    #4 resetn = 1'b0;
    @(negedge CLOCK_50_I);
    nchk++; if ({seq_state, m1_start, sram_we_n, vga_enable} !== {3'd0, 3'b011}) begin nerr++; $display("FAIL mid_reset: got st=%0d m1s=%b we_n=%b vga=%b required 0/0/1/1", seq_state, m1_start, sram_we_n, vga_enable); end
    m1_sram_we_n = 1'b1;
    resetn = 1'b1;
    @(negedge CLOCK_50_I);
  endtask

  task automatic test_watchdog();
    int n;
    UART_RX_I = 1'b0;
    @(negedge CLOCK_50_I);
    UART_RX_I = 1'b1;
    wait_state(3'd2, UT + 20);
    wait_state(3'd3, 10);
    n = 0;
`ifdef SEQ_WATCHDOG_EN
    while (seq_error !== 1'b1 && n < WD + 50) begin
      @(negedge CLOCK_50_I);
      n++;
    end
    nchk++; if (n !== WD) begin nerr++; $display("FAIL wdog_cycles: got %0d required %0d", n, WD); end
    nchk++; if ({seq_state, m2_start, vga_enable, sram_we_n} !== {3'd5, 3'b001}) begin nerr++; $display("FAIL wdog_err: got st=%0d m2s=%b vga=%b we_n=%b required 5/0/0/1", seq_state, m2_start, vga_enable, sram_we_n); end
`else
    repeat (5000) @(negedge CLOCK_50_I);
    nchk++; if ({seq_state, seq_error, m2_start} !== {3'd3, 2'b01}) begin nerr++; $display("FAIL no_wdog: got st=%0d err=%b m2s=%b required 3/0/1", seq_state, seq_error, m2_start); end
`endif
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1.5ms");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge CLOCK_50_I);
    test_reset();
    test_uart_rx();
    test_guard_to_m2();
    test_m2_m1();
    test_reset_mid_m1();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
